// File: rtl/data_memory_ctrl.sv
// Data memory controller: 3-state IDLE/ACCESS/DONE load/store engine in front of a word-addressed RAM.
// Optional macro DATA_MEMORY_CTRL_ALIGN_CHECK_EN flags misaligned addresses as errors.
module data_memory_ctrl #(
    parameter int DATAWIDTH_BUS = 32,
    parameter int DEPTH_LOG2    = 6
) (
    input  logic                     CC_DATAMEMORY_CLOCK_50,
    input  logic                     CC_DATAMEMORY_RESET_InHigh,
    input  logic                     CC_DataMemory_Read_In,
    input  logic                     CC_DataMemory_Write_In,
    input  logic [DATAWIDTH_BUS-1:0] CC_DataMemory_Address_In,
    input  logic [DATAWIDTH_BUS-1:0] CC_DataMemory_Data_Bus_In,
    output logic [DATAWIDTH_BUS-1:0] CC_DataMemory_Data_Bus_Out,
    output logic                     CC_DataMemory_Selector_Out,
    output logic                     CC_DataMemory_Busy_Out,
    output logic                     CC_DataMemory_Done_Out,
    output logic                     CC_DataMemory_Error_Out
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    logic                     clk;
    logic                     srst;
    logic                     rd_req;
    logic                     wr_req;
    logic                     misaligned;
    logic                     mem_we;
    logic                     unused_addr_bits;

    state_t                   state_reg;
    logic [DEPTH_LOG2-1:0]    index_reg;
    logic [DATAWIDTH_BUS-1:0] wdata_reg;
    logic                     load_reg;
    logic                     store_reg;
    logic                     fault_reg;
    logic [DATAWIDTH_BUS-1:0] rdata_reg;
    logic                     sel_reg;
    logic                     busy_reg;
    logic                     done_reg;
    logic                     error_reg;

    logic [DATAWIDTH_BUS-1:0] mem [0:DEPTH-1];

    assign clk    = CC_DATAMEMORY_CLOCK_50;
    assign srst   = CC_DATAMEMORY_RESET_InHigh;
    assign rd_req = CC_DataMemory_Read_In;
    assign wr_req = CC_DataMemory_Write_In;

`ifdef DATA_MEMORY_CTRL_ALIGN_CHECK_EN
    assign misaligned = |CC_DataMemory_Address_In[1:0];
`else
    assign misaligned = 1'b0;
`endif

    // Upper address bits fold onto the RAM (wrap), and the byte offset is dropped.
    assign unused_addr_bits = ^{CC_DataMemory_Address_In[DATAWIDTH_BUS-1:DEPTH_LOG2+2],
                                CC_DataMemory_Address_In[1:0]};

    // Write commits on the edge leaving ACCESS; a reset on that edge aborts it.
    assign mem_we = (state_reg == ACCESS) && store_reg && !srst;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[index_reg] <= wdata_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= IDLE;
            index_reg <= '0;
            wdata_reg <= '0;
            load_reg  <= 1'b0;
            store_reg <= 1'b0;
            fault_reg <= 1'b0;
            rdata_reg <= '0;
            sel_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    sel_reg   <= 1'b0;
                    done_reg  <= 1'b0;
                    error_reg <= 1'b0;
                    if (rd_req || wr_req) begin
                        state_reg <= ACCESS;
                        busy_reg  <= 1'b1;
                        index_reg <= CC_DataMemory_Address_In[DEPTH_LOG2+1:2];
                        wdata_reg <= CC_DataMemory_Data_Bus_In;
                        load_reg  <= rd_req && !wr_req && !misaligned;
                        store_reg <= wr_req && !rd_req && !misaligned;
                        fault_reg <= (rd_req && wr_req) || misaligned;
                    end
                end
                ACCESS: begin
                    state_reg <= DONE;
                    done_reg  <= 1'b1;
                    error_reg <= fault_reg;
                    sel_reg   <= load_reg;
                    if (load_reg) begin
                        rdata_reg <= mem[index_reg];
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    error_reg <= 1'b0;
                    sel_reg   <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    error_reg <= 1'b0;
                    sel_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign CC_DataMemory_Data_Bus_Out = rdata_reg;
    assign CC_DataMemory_Selector_Out = sel_reg;
    assign CC_DataMemory_Busy_Out     = busy_reg;
    assign CC_DataMemory_Done_Out     = done_reg;
    assign CC_DataMemory_Error_Out    = error_reg;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed self-checking bench for data_memory_ctrl (default parameters).
module tb_data_memory_ctrl;
    logic        clk;
    logic        srst;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        sel;
    logic        busy;
    logic        done;
    logic        err;

    int          tests_run;
    int          tests_failed;
    logic [31:0] exp_rdata;

    data_memory_ctrl #(.DATAWIDTH_BUS(32), .DEPTH_LOG2(6)) dut (
        .CC_DATAMEMORY_CLOCK_50    (clk),
        .CC_DATAMEMORY_RESET_InHigh(srst),
        .CC_DataMemory_Read_In     (rd),
        .CC_DataMemory_Write_In    (wr),
        .CC_DataMemory_Address_In  (addr),
        .CC_DataMemory_Data_Bus_In (din),
        .CC_DataMemory_Data_Bus_Out(dout),
        .CC_DataMemory_Selector_Out(sel),
        .CC_DataMemory_Busy_Out    (busy),
        .CC_DataMemory_Done_Out    (done),
        .CC_DataMemory_Error_Out   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access from IDLE; called 1 time unit after a rising edge.
    task automatic do_access(input logic r, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic exp_err, input logic exp_sel);
        rd = r; wr = w; addr = a; din = d;
        tick();
        rd = 1'b0; wr = 1'b0;
        check("access_busy", {31'b0, busy}, 32'd1);
        check("access_done_low", {31'b0, done}, 32'd0);
        tick();
        if (exp_sel) exp_rdata = d;
        check("done_pulse", {31'b0, done}, 32'd1);
        check("done_busy", {31'b0, busy}, 32'd1);
        check("done_error", {31'b0, err}, {31'b0, exp_err});
        check("done_selector", {31'b0, sel}, {31'b0, exp_sel});
        check("done_data", dout, exp_rdata);
        $display("[TB] rd=%0b wr=%0b addr=%h din=%h -> dout=%h sel=%0b err=%0b",
                 r, w, a, d, dout, sel, err);
        tick();
        check("idle_busy", {31'b0, busy}, 32'd0);
        check("idle_done", {31'b0, done}, 32'd0);
        check("idle_selector", {31'b0, sel}, 32'd0);
        check("idle_data_hold", dout, exp_rdata);
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        exp_rdata = 32'h0;
        srst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 32'h0; din = 32'h0;
        tick();
        tick();
        srst = 1'b0;
        check("rst_data", dout, 32'h0);
        check("rst_flags", {28'b0, sel, busy, done, err}, 32'h0);
        tick();

        // Store then load; for loads the d argument is the expected read data.
        do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0);
        do_access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1);

        // Address wrap modulo 64 words.
        do_access(1'b0, 1'b1, 32'h104, 32'h12345678, 1'b0, 1'b0);
        do_access(1'b1, 1'b0, 32'h004, 32'h12345678, 1'b0, 1'b1);

        // Simultaneous read and write is an error with no memory access.
        do_access(1'b0, 1'b1, 32'h20, 32'hAAAA5555, 1'b0, 1'b0);
        do_access(1'b1, 1'b1, 32'h20, 32'h00000000, 1'b1, 1'b0);
        do_access(1'b1, 1'b0, 32'h20, 32'hAAAA5555, 1'b0, 1'b1);

        // A second store pulsed while busy is dropped.
        rd = 1'b0; wr = 1'b1; addr = 32'h30; din = 32'hCAFEF00D;
        tick();
        din = 32'hBAD0BAD0;
        tick();
        wr = 1'b0;
        check("poke_done", {31'b0, done}, 32'd1);
        tick();
        check("poke_idle", {31'b0, busy}, 32'd0);
        tick();
        check("poke_not_queued", {31'b0, busy}, 32'd0);
        do_access(1'b1, 1'b0, 32'h30, 32'hCAFEF00D, 1'b0, 1'b1);

        // Reset during ACCESS aborts the store.
        do_access(1'b0, 1'b1, 32'h40, 32'h11111111, 1'b0, 1'b0);
        wr = 1'b1; addr = 32'h40; din = 32'h0000FFFF;
        tick();
        wr = 1'b0;
        srst = 1'b1;
        tick();
        srst = 1'b0;
        exp_rdata = 32'h0;
        check("abort_data", dout, 32'h0);
        check("abort_flags", {28'b0, sel, busy, done, err}, 32'h0);
        tick();
        check("abort_no_done", {31'b0, done}, 32'd0);
        do_access(1'b1, 1'b0, 32'h40, 32'h11111111, 1'b0, 1'b1);

        // Misaligned load after a load of a different word.
        do_access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1);
`ifdef DATA_MEMORY_CTRL_ALIGN_CHECK_EN
        do_access(1'b1, 1'b0, 32'h42, 32'h00000000, 1'b1, 1'b0);
`else
        do_access(1'b1, 1'b0, 32'h42, 32'h11111111, 1'b0, 1'b1);
`endif

        // A read held high is re-accepted right after DONE.
        rd = 1'b1; addr = 32'h10;
        tick();
        check("held_busy1", {31'b0, busy}, 32'd1);
        tick();
        check("held_done1", {31'b0, done}, 32'd1);
        check("held_data1", dout, 32'hDEADBEEF);
        tick();
        check("held_idle", {31'b0, busy}, 32'd0);
        tick();
        check("held_busy2", {31'b0, busy}, 32'd1);
        check("held_done_low", {31'b0, done}, 32'd0);
        tick();
        rd = 1'b0;
        check("held_done2", {31'b0, done}, 32'd1);
        check("held_sel2", {31'b0, sel}, 32'd1);
        tick();
        tick();
        check("held_released", {31'b0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
